// File: rtl/switch_nport.sv
// N-port packet switch: per-input FIFOs with multicast head masks, per-output
// round-robin arbiters feeding registered valid/ready output slots.
module switch_nport #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SRC_W      = $clog2(NUM_PORTS),
    parameter int unsigned CNT_W      = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_PORTS-1:0]                  in_valid,
    output logic [NUM_PORTS-1:0]                  in_ready,
    input  logic [NUM_PORTS*(NUM_PORTS+DATA_W)-1:0] in_data,
    output logic [NUM_PORTS-1:0]                  out_valid,
    input  logic [NUM_PORTS-1:0]                  out_ready,
    output logic [NUM_PORTS*(SRC_W+DATA_W)-1:0]   out_data,
    output logic [CNT_W-1:0]                      drop_count
);
    localparam int unsigned IW = NUM_PORTS + DATA_W;
    localparam int unsigned OW = SRC_W + DATA_W;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [IW-1:0]                       r_mem [NUM_PORTS][FIFO_DEPTH];
    logic [AW-1:0]                       r_wp  [NUM_PORTS];
    logic [AW-1:0]                       r_rp  [NUM_PORTS];
    logic [CW-1:0]                       r_cnt [NUM_PORTS];
    logic [NUM_PORTS-1:0]                r_in_ready;
    logic [NUM_PORTS-1:0]                r_hv;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] r_rem;
    logic [SRC_W-1:0]                    r_ptr [NUM_PORTS];
    logic [NUM_PORTS-1:0]                r_ov;
    logic [OW-1:0]                       r_od  [NUM_PORTS];
    logic [CNT_W-1:0]                    r_drop;

    logic [NUM_PORTS-1:0]                w_acc;
    logic [NUM_PORTS-1:0]                w_push;
    logic [NUM_PORTS-1:0]                w_drop;
    logic [NUM_PORTS-1:0]                w_pop;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_clr;
    logic [NUM_PORTS-1:0]                w_gv;
    logic [SRC_W-1:0]                    w_gsel    [NUM_PORTS];
    logic [CW-1:0]                       w_cnt_nxt [NUM_PORTS];
    logic [IW-1:0]                       w_head    [NUM_PORTS];
    logic [CNT_W-1:0]                    w_drop_nxt;

    // Input accept decode: zero-mask beats are counted, never stored
    always_comb begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            w_acc[i]  = in_valid[i] & r_in_ready[i];
            w_push[i] = w_acc[i] & (|in_data[i*IW+DATA_W +: NUM_PORTS]);
            w_drop[i] = w_acc[i] & ~(|in_data[i*IW+DATA_W +: NUM_PORTS]);
            w_head[i] = r_mem[i][r_rp[i]];
        end
    end

    // Per-output round-robin arbitration; w_clr[i][j] marks input i granted by output j
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        w_clr = '0;
        w_gv  = '0;
        for (int j = 0; j < int'(NUM_PORTS); j++) begin
            w_gsel[j] = '0;
            found     = 1'b0;
            if (!r_ov[j] || out_ready[j]) begin
                for (int k = 0; k < int'(NUM_PORTS); k++) begin
                    idx = (int'(r_ptr[j]) + k) % int'(NUM_PORTS);
                    if (!found && r_hv[idx] && r_rem[idx][j]) begin
                        found     = 1'b1;
                        w_gsel[j] = SRC_W'(idx);
                    end
                end
            end
            w_gv[j] = found;
            if (found) w_clr[w_gsel[j]][j] = 1'b1;
        end
    end

    // Pop once the last outstanding destination of the head is granted
    always_comb begin
        w_drop_nxt = r_drop;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            w_pop[i]     = r_hv[i] & ~(|(r_rem[i] & ~w_clr[i]));
            w_cnt_nxt[i] = r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
            if (w_drop[i] && (w_drop_nxt != '1)) w_drop_nxt = w_drop_nxt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (w_push[i]) r_mem[i][r_wp[i]] <= in_data[i*IW +: IW];
        end
    end

    // Input side: FIFO pointers, registered ready, head remaining-mask tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end
            r_in_ready <= '0;
            r_hv       <= '0;
            r_rem      <= '0;
            r_drop     <= '0;
        end else begin
            r_drop <= w_drop_nxt;
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                r_cnt[i]      <= w_cnt_nxt[i];
                r_in_ready[i] <= (w_cnt_nxt[i] != CW'(FIFO_DEPTH));
                if (w_push[i]) r_wp[i] <= r_wp[i] + AW'(1);
                if (w_pop[i]) begin
                    r_rp[i]  <= r_rp[i] + AW'(1);
                    r_hv[i]  <= 1'b0;
                    r_rem[i] <= '0;
                end else if (r_hv[i]) begin
                    r_rem[i] <= r_rem[i] & ~w_clr[i];
                end else if (r_cnt[i] != '0) begin
                    r_hv[i]  <= 1'b1;
                    r_rem[i] <= w_head[i][IW-1 -: NUM_PORTS];
                end
            end
        end
    end

    // Output slots: load on empty or handshake, hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < int'(NUM_PORTS); j++) begin
                r_ptr[j] <= '0;
                r_od[j]  <= '0;
            end
            r_ov <= '0;
        end else begin
            for (int j = 0; j < int'(NUM_PORTS); j++) begin
                if (!r_ov[j] || out_ready[j]) begin
                    r_ov[j] <= w_gv[j];
                    if (w_gv[j]) begin
                        r_od[j]  <= {w_gsel[j], w_head[w_gsel[j]][DATA_W-1:0]};
                        r_ptr[j] <= (w_gsel[j] == SRC_W'(NUM_PORTS - 1)) ? '0
                                                                         : w_gsel[j] + SRC_W'(1);
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_PORTS); g++) begin : g_out
        assign out_data[g*OW +: OW] = r_od[g];
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_ov;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_switch_nport.sv
// Bench for switch_nport: directed scenarios plus random traffic scored against
// per-(source,destination) ordered payload queues.
module tb_switch_nport;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = N + DW;
    localparam int SW = 2;
    localparam int OW = SW + DW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic [N*IW-1:0] in_data = '0;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready = '0;
    logic [N*OW-1:0] out_data;
    logic [15:0]     drop_count;
    logic [N-1:0]    in_ready2;
    logic [N-1:0]    out_valid2;
    logic [N*OW-1:0] out_data2;
    logic [1:0]      drop_count2;

    int        n_checks = 0;
    int        n_fail   = 0;
    logic [7:0] q_exp [N*N][$];
    int        exp_drops;
    int        exp_drops2;
    int        n_deliv [N];
    logic [N-1:0]  prev_hold;
    logic [OW-1:0] prev_od [N];

    switch_nport #(.NUM_PORTS(N), .DATA_W(DW), .FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .drop_count(drop_count));

    switch_nport #(.NUM_PORTS(N), .DATA_W(DW), .FIFO_DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .drop_count(drop_count2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] od(input int j);
        return out_data[j*OW +: OW];
    endfunction

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < N*N; k++) s += q_exp[k].size();
        return s;
    endfunction

    function automatic int total_deliv();
        int s = 0;
        for (int j = 0; j < N; j++) s += n_deliv[j];
        return s;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < N*N; k++) q_exp[k].delete();
        exp_drops  = 0;
        exp_drops2 = 0;
        prev_hold  = '0;
    endtask

    task automatic drive(input int i, input logic v, input logic [N-1:0] m, input logic [7:0] p);
        in_valid[i]         = v;
        in_data[i*IW +: IW] = {m, p};
    endtask

    // Reference model: record accepts and score deliveries visible before the next edge
    task automatic observe();
        logic [N-1:0]  m;
        logic [7:0]    p;
        logic [OW-1:0] o;
        logic [8:0]    ev;
        int            s;
        for (int i = 0; i < N; i++) begin
            if (in_valid[i] && in_ready[i]) begin
                m = in_data[i*IW+DW +: N];
                p = in_data[i*IW +: DW];
                if (m == '0) begin
                    if (exp_drops < 65535) exp_drops++;
                    if (exp_drops2 < 3) exp_drops2++;
                end else begin
                    for (int j = 0; j < N; j++) if (m[j]) q_exp[i*N+j].push_back(p);
                end
            end
        end
        for (int j = 0; j < N; j++) begin
            o = od(j);
            if (prev_hold[j]) chk($sformatf("hold_out%0d", j), 32'({out_valid[j], o}), 32'({1'b1, prev_od[j]}));
            if (out_valid[j] && out_ready[j]) begin
                s  = int'(o[OW-1 -: SW]);
                ev = 9'h100;
                if (q_exp[s*N+j].size() > 0) ev = {1'b0, q_exp[s*N+j].pop_front()};
                chk($sformatf("deliver_out%0d_src%0d", j, s), 32'({1'b0, o[DW-1:0]}), 32'(ev));
                n_deliv[j]++;
            end
            prev_hold[j] = out_valid[j] && !out_ready[j];
            prev_od[j]   = o;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int base;
        logic take;
        clear_model();
        for (int j = 0; j < N; j++) n_deliv[j] = 0;
        out_ready = '1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_drop_count", 32'(drop_count), 32'(0));
        chk("rst_out_data_zero", 32'(|out_data), 32'(0));
        repeat (2) cycle();
        rst_n = 1'b1;
        chk("ready_before_first_edge", 32'(in_ready), 32'(0));
        cycle();
        chk("ready_after_release", 32'(in_ready), 32'(4'hF));

        // Unicast: out_valid two edges after accept
        drive(0, 1'b1, 4'b0100, 8'hA5);
        cycle();
        drive(0, 1'b0, '0, '0);
        cycle();
        chk("uni_not_early", 32'(out_valid), 32'(0));
        cycle();
        chk("uni_valid", 32'(out_valid), 32'(4'b0100));
        chk("uni_data", 32'(od(2)), 32'({2'd0, 8'hA5}));
        cycle();

        // Contention on output 0, two rounds, rotating order
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) drive(i, 1'b1, 4'b0001, 8'(8'h10 + 16*r + i));
            cycle();
            for (int i = 0; i < N; i++) drive(i, 1'b0, '0, '0);
            cycle();
            for (int k = 0; k < N; k++) begin
                cycle();
                chk($sformatf("cont_r%0d_valid%0d", r, k), 32'(out_valid), 32'(4'b0001));
                chk($sformatf("cont_r%0d_data%0d", r, k), 32'(od(0)), 32'({2'(k), 8'(8'h10 + 16*r + k)}));
            end
        end
        cycle();

        // Multicast with output 3 backpressured behind an earlier packet
        out_ready = 4'b0111;
        drive(2, 1'b1, 4'b1000, 8'h77);
        cycle();
        drive(2, 1'b0, '0, '0);
        cycle();
        cycle();
        chk("mc_pre_hold", 32'(out_valid), 32'(4'b1000));
        drive(1, 1'b1, 4'b1011, 8'h3C);
        cycle();
        drive(1, 1'b1, 4'b0001, 8'h5A);
        cycle();
        drive(1, 1'b0, '0, '0);
        cycle();
        chk("mc_fanout_valid", 32'(out_valid), 32'(4'b1011));
        chk("mc_out0", 32'(od(0)), 32'({2'd1, 8'h3C}));
        chk("mc_out1", 32'(od(1)), 32'({2'd1, 8'h3C}));
        chk("mc_out3_old", 32'(od(3)), 32'({2'd2, 8'h77}));
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk($sformatf("mc_blocked%0d", k), 32'(out_valid), 32'(4'b1000));
        end
        out_ready = '1;
        cycle();
        chk("mc_late_valid", 32'(out_valid), 32'(4'b1000));
        chk("mc_late_data", 32'(od(3)), 32'({2'd1, 8'h3C}));
        cycle();
        chk("mc_once", 32'(out_valid), 32'(0));
        cycle();
        chk("mc_next_valid", 32'(out_valid), 32'(4'b0001));
        chk("mc_next_data", 32'(od(0)), 32'({2'd1, 8'h5A}));
        cycle();

        // FIFO full under total backpressure
        out_ready = '0;
        acc = 0;
        drive(0, 1'b1, 4'b0010, 8'hB0);
        for (int c = 0; c < 8; c++) begin
            take = in_ready[0];
            cycle();
            if (take) begin
                acc++;
                drive(0, 1'b1, 4'b0010, 8'(8'hB0 + acc));
            end
        end
        chk("full_accepts", 32'(acc), 32'(5));
        chk("full_ready_low", 32'(in_ready[0]), 32'(0));
        drive(0, 1'b0, '0, '0);
        base = n_deliv[1];
        out_ready = '1;
        repeat (16) cycle();
        chk("full_delivered", 32'(n_deliv[1] - base), 32'(5));

        // Drops and counter saturation
        drive(3, 1'b1, 4'b0000, 8'hEE);
        repeat (3) cycle();
        drive(3, 1'b0, '0, '0);
        chk("drop3", 32'(drop_count), 32'(3));
        chk("drop3_narrow", 32'(drop_count2), 32'(3));
        chk("drop_no_valid", 32'(out_valid), 32'(0));
        drive(3, 1'b1, 4'b0000, 8'hEF);
        repeat (2) cycle();
        drive(3, 1'b0, '0, '0);
        chk("drop5", 32'(drop_count), 32'(5));
        chk("drop5_narrow_sat", 32'(drop_count2), 32'(3));

        // Reset while packets are buffered
        out_ready = '0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 4'b0100, 8'(8'hD0 + k));
            cycle();
        end
        drive(0, 1'b0, '0, '0);
        cycle();
        cycle();
        chk("pre_rst_valid", 32'(out_valid), 32'(4'b0100));
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("midrst_valid", 32'(out_valid), 32'(0));
        chk("midrst_ready", 32'(in_ready), 32'(0));
        chk("midrst_drop", 32'(drop_count), 32'(0));
        cycle();
        rst_n = 1'b1;
        out_ready = '1;
        cycle();
        chk("post_rst_ready", 32'(in_ready), 32'(4'hF));
        base = total_deliv();
        repeat (8) cycle();
        chk("post_rst_quiet", 32'(total_deliv() - base), 32'(0));
        drive(3, 1'b1, 4'b0001, 8'hC3);
        cycle();
        drive(3, 1'b0, '0, '0);
        cycle();
        cycle();
        chk("post_rst_valid", 32'(out_valid), 32'(4'b0001));
        chk("post_rst_data", 32'(od(0)), 32'({2'd3, 8'hC3}));
        cycle();

        // Random traffic against the queue model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                logic [N-1:0] m;
                m = N'($urandom);
                if ($urandom_range(0, 9) == 0) m = '0;
                drive(i, 1'($urandom_range(0, 1)), m, 8'($urandom));
            end
            out_ready = N'($urandom);
            cycle();
        end
        for (int i = 0; i < N; i++) drive(i, 1'b0, '0, '0);
        out_ready = '1;
        repeat (100) cycle();
        chk("rand_all_delivered", 32'(pending()), 32'(0));
        chk("rand_drop_count", 32'(drop_count), 32'(exp_drops));
        chk("rand_drop_narrow", 32'(drop_count2), 32'(exp_drops2));
        chk("rand_idle_valid", 32'(out_valid), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
